// File: rtl/muladd8_top.sv
// muladd8_top: sequential shift-add reconstruction of a dividend Y = Q*B + R with a validity flag
module muladd8_top #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   Q,
  input  logic [W-1:0]   B,
  input  logic [W-1:0]   R,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [2*W-1:0] Y,
  output logic [W-1:0]   A
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] q_q, q_d, b_q, b_d, r_q, r_d;
  logic [2*W-1:0] acc_q, acc_d, y_q, y_d, add;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, last;
  assign add = q_q[cnt_q] ? {{W{1'b0}}, b_q} << cnt_q : '0;
  assign last = cnt_q == CW'(W - 1);
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    b_d = b_q;
    r_d = r_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    y_d = y_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        q_d = Q;
        b_d = B;
        r_d = R;
        acc_d = {{W{1'b0}}, R};
        cnt_d = '0;
      end
      CALC: begin
        acc_d = acc_q + add;
        cnt_d = cnt_q + CW'(1);
        state_d = last ? DONE : CALC;
        y_d = last ? acc_d : y_q;
        err_d = last ? (b_q == '0 || r_q >= b_q || |acc_d[2*W-1:W]) : err_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q <= '0;
      b_q <= '0;
      r_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      y_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      b_q <= b_d;
      r_q <= r_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      y_q <= y_d;
      err_q <= err_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err = err_q;
  assign Y = y_q;
  assign A = y_q[W-1:0];
endmodule

// File: tb/tb_muladd8_top.sv
// tb_muladd8_top: directed and random scoreboard bench for muladd8_top
module tb_muladd8_top;
  typedef struct packed {
    logic [15:0] y;
    logic        e;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] q = '0, b = '0, r = '0, a;
  logic busy, done, err;
  logic [15:0] y;
  exp_t sb[$];
  int errors = 0, checks = 0, done_cnt = 0;
  muladd8_top #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .Q(q), .B(b), .R(r),
    .busy(busy), .done(done), .err(err), .Y(y), .A(a)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  always @(negedge clk) if (done) begin
    exp_t e;
    done_cnt++;
    if (sb.size() == 0) chk("unexpected_done", done_cnt, 0);
    else begin
      e = sb.pop_front();
      chk("Y", y, e.y);
      chk("A", a, e.y[7:0]);
      chk("err", err, e.e);
    end
  end
  task automatic wait_done();
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    chk("done_timeout", done, 1);
  endtask
  task automatic op(input logic [7:0] qi, bi, ri, input logic [15:0] ey, input logic ee);
    sb.push_back('{ey, ee});
    @(negedge clk);
    q = qi; b = bi; r = ri; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    q = 8'($urandom); b = 8'($urandom); r = 8'($urandom);
    wait_done();
    repeat (3) @(negedge clk);
    chk("hold_Y", y, ey);
    chk("hold_err", err, ee);
  endtask
  initial begin
    int d0;
    logic [15:0] m;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_Y", y, 0);
    chk("rst_A", a, 0);
    rst = 1'b0;
    // nominal with cycle-exact busy/done timing
    sb.push_back('{16'd174, 1'b0});
    q = 8'd6; b = 8'd25; r = 8'd24; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("busy_c%0d", c), busy, c <= 8);
      chk($sformatf("done_c%0d", c), done, c == 8);
      @(negedge clk);
    end
    op(8'd0, 8'd25, 8'd0, 16'd0, 1'b0);
    op(8'd1, 8'd50, 8'd0, 16'd50, 1'b0);
    op(8'd37, 8'd0, 8'd0, 16'd0, 1'b1);
    op(8'd2, 8'd25, 8'd30, 16'd80, 1'b1);
    op(8'd255, 8'd255, 8'd254, 16'd65279, 1'b1);
    op(8'd10, 8'd25, 8'd24, 16'd274, 1'b1);
    // start while busy is ignored
    d0 = done_cnt;
    sb.push_back('{16'd174, 1'b0});
    @(negedge clk);
    q = 8'd6; b = 8'd25; r = 8'd24; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    q = 8'd1; b = 8'd1; r = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);
    chk("busy_start_dones", done_cnt - d0, 1);
    // reset mid-operation
    d0 = done_cnt;
    q = 8'd6; b = 8'd25; r = 8'd24; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_Y", y, 0);
    chk("abort_err", err, 0);
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    op(8'd3, 8'd7, 8'd2, 16'd23, 1'b0);
    // back-to-back with start held high
    d0 = done_cnt;
    sb.push_back('{16'd174, 1'b0});
    sb.push_back('{16'd174, 1'b0});
    q = 8'd6; b = 8'd25; r = 8'd24; start = 1'b1;
    for (int i = 0; i < 19; i++) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && done_cnt - d0 < 2; i++) @(negedge clk);
    chk("b2b_dones", done_cnt - d0, 2);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      logic [7:0] rq, rb, rr;
      rq = 8'($urandom); rb = 8'($urandom); rr = 8'($urandom);
      if (i % 4 == 0) rr = 8'($urandom_range(0, 31));
      m = 16'(rq) * 16'(rb) + 16'(rr);
      op(rq, rb, rr, m, rb == 0 || rr >= rb || m > 16'd255);
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
